// File: rtl/id_ex_alu_decode.sv
// ID/EX pipeline register with RV32I ALU-control decode.
// Stall holds, flush or an empty slot loads a bubble, illegal encodings are counted.
module id_ex_alu_decode #(
    parameter int XLEN      = 32,
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          id_instr,
    input  logic                 id_valid,
    input  logic                 stall,
    input  logic                 flush,
    output logic                 ex_valid,
    output logic [2:0]           ex_alu_control,
    output logic                 ex_alu_src_imm,
    output logic [XLEN-1:0]      ex_imm,
    output logic [4:0]           ex_rs1,
    output logic [4:0]           ex_rs2,
    output logic [4:0]           ex_rd,
    output logic                 ex_reg_write,
    output logic                 ex_mem_read,
    output logic                 ex_mem_write,
    output logic                 ex_branch,
    output logic                 ex_branch_ne,
    output logic                 ex_illegal,
    output logic [ILL_CNT_W-1:0] illegal_count
);
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;

    assign w_opcode = id_instr[6:0];
    assign w_f3     = id_instr[14:12];
    assign w_f7     = id_instr[31:25];
    assign w_imm_i  = {{(XLEN-12){id_instr[31]}}, id_instr[31:20]};
    assign w_imm_s  = {{(XLEN-12){id_instr[31]}}, id_instr[31:25],
                       id_instr[11:7]};
    assign w_imm_b  = {{(XLEN-12){id_instr[31]}}, id_instr[7],
                       id_instr[30:25], id_instr[11:8], 1'b0};

    logic [2:0]      w_alu;
    logic            w_src_imm;
    logic [XLEN-1:0] w_imm;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    logic            w_reg_write;
    logic            w_mem_read;
    logic            w_mem_write;
    logic            w_branch;
    logic            w_branch_ne;
    logic            w_illegal;

    always_comb begin
        w_alu       = ALU_ADD;
        w_src_imm   = 1'b0;
        w_imm       = '0;
        w_rs1       = id_instr[19:15];
        w_rs2       = 5'd0;
        w_rd        = 5'd0;
        w_reg_write = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_branch    = 1'b0;
        w_branch_ne = 1'b0;
        w_illegal   = 1'b0;
        unique case (w_opcode)
            OP_R: begin
                w_rs2       = id_instr[24:20];
                w_rd        = id_instr[11:7];
                w_reg_write = 1'b1;
                if (w_f7 == 7'b0000000) begin
                    case (w_f3)
                        3'b000:  w_alu = ALU_ADD;
                        3'b001:  w_alu = ALU_SLL;
                        3'b010:  w_alu = ALU_SLT;
                        3'b100:  w_alu = ALU_XOR;
                        3'b101:  w_alu = ALU_SRL;
                        3'b110:  w_alu = ALU_OR;
                        3'b111:  w_alu = ALU_AND;
                        default: w_illegal = 1'b1;
                    endcase
                end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
                    w_alu = ALU_SUB;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            OP_I: begin
                w_src_imm   = 1'b1;
                w_imm       = w_imm_i;
                w_rd        = id_instr[11:7];
                w_reg_write = 1'b1;
                case (w_f3)
                    3'b000:  w_alu = ALU_ADD;
                    3'b010:  w_alu = ALU_SLT;
                    3'b100:  w_alu = ALU_XOR;
                    3'b110:  w_alu = ALU_OR;
                    3'b111:  w_alu = ALU_AND;
                    3'b001: begin
                        w_alu     = ALU_SLL;
                        w_illegal = (w_f7 != 7'd0);
                    end
                    3'b101: begin
                        w_alu     = ALU_SRL;
                        w_illegal = (w_f7 != 7'd0);
                    end
                    default: w_illegal = 1'b1;
                endcase
            end
            OP_LD: begin
                w_src_imm   = 1'b1;
                w_imm       = w_imm_i;
                w_rd        = id_instr[11:7];
                w_reg_write = 1'b1;
                w_mem_read  = 1'b1;
            end
            OP_ST: begin
                w_src_imm   = 1'b1;
                w_imm       = w_imm_s;
                w_rs2       = id_instr[24:20];
                w_mem_write = 1'b1;
            end
            OP_BR: begin
                w_alu       = ALU_SUB;
                w_imm       = w_imm_b;
                w_rs2       = id_instr[24:20];
                w_branch    = 1'b1;
                w_branch_ne = w_f3[0];
                w_illegal   = (w_f3[2:1] != 2'b00);
            end
            default: w_illegal = 1'b1;
        endcase
        // An illegal slot carries no side effects into EX
        if (w_illegal) begin
            w_alu       = ALU_ADD;
            w_src_imm   = 1'b0;
            w_imm       = '0;
            w_rs1       = 5'd0;
            w_rs2       = 5'd0;
            w_rd        = 5'd0;
            w_reg_write = 1'b0;
            w_mem_read  = 1'b0;
            w_mem_write = 1'b0;
            w_branch    = 1'b0;
            w_branch_ne = 1'b0;
        end
        if (w_rd == 5'd0) begin
            w_reg_write = 1'b0;
        end
    end

    logic w_bubble;
    logic w_load;

    assign w_bubble = flush || (!stall && !id_valid);
    assign w_load   = !flush && !stall && id_valid;

    logic                 r_valid;
    logic [2:0]           r_alu;
    logic                 r_src_imm;
    logic [XLEN-1:0]      r_imm;
    logic [4:0]           r_rs1;
    logic [4:0]           r_rs2;
    logic [4:0]           r_rd;
    logic                 r_reg_write;
    logic                 r_mem_read;
    logic                 r_mem_write;
    logic                 r_branch;
    logic                 r_branch_ne;
    logic                 r_illegal;
    logic [ILL_CNT_W-1:0] r_ill_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || w_bubble) begin
            r_valid     <= 1'b0;
            r_alu       <= ALU_ADD;
            r_src_imm   <= 1'b0;
            r_imm       <= '0;
            r_rs1       <= 5'd0;
            r_rs2       <= 5'd0;
            r_rd        <= 5'd0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_branch    <= 1'b0;
            r_branch_ne <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (w_load) begin
            r_valid     <= 1'b1;
            r_alu       <= w_alu;
            r_src_imm   <= w_src_imm;
            r_imm       <= w_imm;
            r_rs1       <= w_rs1;
            r_rs2       <= w_rs2;
            r_rd        <= w_rd;
            r_reg_write <= w_reg_write;
            r_mem_read  <= w_mem_read;
            r_mem_write <= w_mem_write;
            r_branch    <= w_branch;
            r_branch_ne <= w_branch_ne;
            r_illegal   <= w_illegal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ill_cnt <= '0;
        end else if (w_load && w_illegal && (r_ill_cnt != '1)) begin
            r_ill_cnt <= r_ill_cnt + 1'b1;
        end
    end

    assign ex_valid       = r_valid;
    assign ex_alu_control = r_alu;
    assign ex_alu_src_imm = r_src_imm;
    assign ex_imm         = r_imm;
    assign ex_rs1         = r_rs1;
    assign ex_rs2         = r_rs2;
    assign ex_rd          = r_rd;
    assign ex_reg_write   = r_reg_write;
    assign ex_mem_read    = r_mem_read;
    assign ex_mem_write   = r_mem_write;
    assign ex_branch      = r_branch;
    assign ex_branch_ne   = r_branch_ne;
    assign ex_illegal     = r_illegal;
    assign illegal_count  = r_ill_cnt;
endmodule

// File: tb/tb_id_ex_alu_decode.sv
// Bench for id_ex_alu_decode: directed steps, then random traffic
// against a mnemonic-level reference model.
module tb_id_ex_alu_decode;
    localparam int XLEN = 32;
    localparam int CW   = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [31:0]     id_instr = '0;
    logic            id_valid = 1'b0;
    logic            stall = 1'b0;
    logic            flush = 1'b0;
    logic            ex_valid;
    logic [2:0]      ex_alu_control;
    logic            ex_alu_src_imm;
    logic [XLEN-1:0] ex_imm;
    logic [4:0]      ex_rs1;
    logic [4:0]      ex_rs2;
    logic [4:0]      ex_rd;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic            ex_branch;
    logic            ex_branch_ne;
    logic            ex_illegal;
    logic [CW-1:0]   illegal_count;

    id_ex_alu_decode #(.XLEN(XLEN), .ILL_CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .id_instr(id_instr),
        .id_valid(id_valid), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_alu_control(ex_alu_control),
        .ex_alu_src_imm(ex_alu_src_imm), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
        .ex_branch_ne(ex_branch_ne), .ex_illegal(ex_illegal),
        .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        v;
        bit [2:0]  alu;
        bit        src;
        bit [31:0] imm;
        bit [4:0]  rs1, rs2, rd;
        bit        rw, mr, mw, br, bne, ill;
        bit        c_imm, c_rs1, c_rs2, c_rd;
    } exp_t;

    exp_t        e;
    int unsigned cnt = 0;
    int          checks = 0;
    int          errors = 0;

    function automatic string mnem(logic [31:0] x);
        logic [2:0] f3 = x[14:12];
        logic [6:0] f7 = x[31:25];
        string n3[8] = '{"add", "sll", "slt", "sltu",
                         "xor", "srl", "or", "and"};
        case (x[6:0])
            7'h33: begin
                if (f7 == 7'h00 && f3 != 3'd3) return n3[f3];
                if (f7 == 7'h20 && f3 == 3'd0) return "sub";
                return "ill";
            end
            7'h13: begin
                if (f3 == 3'd3) return "ill";
                if ((f3 == 3'd1 || f3 == 3'd5) && f7 != 0) return "ill";
                return {n3[f3], "i"};
            end
            7'h03: return "lw";
            7'h23: return "sw";
            7'h63: begin
                if (f3 == 3'd0) return "beq";
                if (f3 == 3'd1) return "bne";
                return "ill";
            end
            default: return "ill";
        endcase
    endfunction

    function automatic bit [2:0] alu_of(string m);
        if (m == "sub" || m == "beq" || m == "bne") return 3'd1;
        if (m == "and" || m == "andi") return 3'd2;
        if (m == "or" || m == "ori") return 3'd3;
        if (m == "xor" || m == "xori") return 3'd4;
        if (m == "slt" || m == "slti") return 3'd5;
        if (m == "sll" || m == "slli") return 3'd6;
        if (m == "srl" || m == "srli") return 3'd7;
        return 3'd0;
    endfunction

    function automatic exp_t bubble();
        exp_t r = '{default: 0};
        r.c_imm = 1; r.c_rs1 = 1; r.c_rs2 = 1; r.c_rd = 1;
        return r;
    endfunction

    function automatic exp_t model(logic [31:0] x);
        exp_t  r = '{default: 0};
        string m = mnem(x);
        r.v = 1;
        if (m == "ill") begin
            r.ill = 1;
            return r;
        end
        r.alu = alu_of(m);
        r.rs1 = x[19:15]; r.c_rs1 = 1;
        case (x[6:0])
            7'h33: begin
                r.rs2 = x[24:20]; r.c_rs2 = 1;
                r.rd = x[11:7]; r.c_rd = 1;
                r.rw = (r.rd != 0);
            end
            7'h13, 7'h03: begin
                r.imm = 32'($signed(x) >>> 20); r.c_imm = 1;
                r.src = 1;
                r.rd = x[11:7]; r.c_rd = 1;
                r.rw = (r.rd != 0);
                r.mr = (x[6:0] == 7'h03);
                r.c_rs2 = (x[6:0] == 7'h13);
            end
            7'h23: begin
                r.imm = (32'($signed(x) >>> 25) << 5) | 32'(x[11:7]);
                r.c_imm = 1;
                r.src = 1; r.mw = 1;
                r.rs2 = x[24:20]; r.c_rs2 = 1;
                r.c_rd = 1;
            end
            default: begin
                r.imm = (32'($signed(x) >>> 31) << 12) | (32'(x[7]) << 11)
                      | (32'(x[30:25]) << 5) | (32'(x[11:8]) << 1);
                r.c_imm = 1;
                r.br = 1; r.bne = x[12];
                r.rs2 = x[24:20]; r.c_rs2 = 1;
            end
        endcase
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".valid"}, 32'(ex_valid), 32'(e.v));
        chk({tag, ".alu"}, 32'(ex_alu_control), 32'(e.alu));
        chk({tag, ".src_imm"}, 32'(ex_alu_src_imm), 32'(e.src));
        chk({tag, ".reg_write"}, 32'(ex_reg_write), 32'(e.rw));
        chk({tag, ".mem_read"}, 32'(ex_mem_read), 32'(e.mr));
        chk({tag, ".mem_write"}, 32'(ex_mem_write), 32'(e.mw));
        chk({tag, ".branch"}, 32'(ex_branch), 32'(e.br));
        chk({tag, ".branch_ne"}, 32'(ex_branch_ne), 32'(e.bne));
        chk({tag, ".illegal"}, 32'(ex_illegal), 32'(e.ill));
        chk({tag, ".ill_cnt"}, 32'(illegal_count), cnt);
        if (e.c_imm) chk({tag, ".imm"}, ex_imm, e.imm);
        if (e.c_rs1) chk({tag, ".rs1"}, 32'(ex_rs1), 32'(e.rs1));
        if (e.c_rs2) chk({tag, ".rs2"}, 32'(ex_rs2), 32'(e.rs2));
        if (e.c_rd) chk({tag, ".rd"}, 32'(ex_rd), 32'(e.rd));
    endtask

    task automatic cycle(logic [31:0] ins, logic v, logic st,
                         logic fl, string tag);
        id_instr = ins; id_valid = v; stall = st; flush = fl;
        if (fl || (!st && !v)) begin
            e = bubble();
        end else if (!st) begin
            e = model(ins);
            if (e.ill && cnt < 255) cnt++;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] x = $urandom;
        logic [6:0]  ops[5] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63};
        int          k = $urandom_range(0, 5);
        if (k < 5) x[6:0] = ops[k];
        if ($urandom_range(0, 2) != 0) x[31:25] = 7'h00;
        else if ($urandom_range(0, 1) != 0) x[31:25] = 7'h20;
        if ($urandom_range(0, 9) == 0) x[11:7] = 5'd0;
        return x;
    endfunction

    initial begin
        e = bubble();
        #2;
        check_all("reset");
        #5 rst_n = 1'b1;

        cycle(32'h002081B3, 1, 0, 0, "add");
        chk("add.rd3", 32'(ex_rd), 32'd3);
        cycle(32'h402081B3, 1, 0, 0, "sub");
        chk("sub.alu", 32'(ex_alu_control), 32'd1);
        cycle(32'hFFF00293, 1, 0, 0, "addi");
        chk("addi.imm", ex_imm, 32'hFFFFFFFF);
        cycle(32'hFE208CE3, 1, 0, 0, "beq");
        chk("beq.imm", ex_imm, 32'hFFFFFFF8);
        cycle(32'h4020D1B3, 1, 0, 0, "sra");
        chk("sra.cnt", 32'(illegal_count), 32'd1);
        for (int i = 0; i < 256; i++) begin
            cycle((i % 2) ? 32'h4020D1B3 : 32'h0000007F, 1, 0, 0, "sat");
        end
        chk("sat.cnt", 32'(illegal_count), 32'd255);

        cycle(32'h002081B3, 1, 0, 0, "hold.add");
        for (int i = 0; i < 3; i++) begin
            cycle(32'h402081B3, 1, 1, 0, "hold.stall");
        end
        chk("hold.alu", 32'(ex_alu_control), 32'd0);
        cycle(32'h4020D1B3, 1, 1, 1, "stall_flush");
        cycle(32'h002081B3, 1, 0, 0, "pre_rst");
        cycle(32'h402081B3, 1, 1, 0, "pre_rst.stall");
        #3 rst_n = 1'b0;
        e = bubble();
        cnt = 0;
        #1;
        check_all("async_rst");
        #2 rst_n = 1'b1;

        cycle(32'h00000033, 1, 0, 0, "add_x0");
        cycle(32'h00000033, 0, 0, 0, "no_valid");

        for (int i = 0; i < 400; i++) begin
            cycle(rnd_instr(), ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 6) == 0),
                  ($urandom_range(0, 9) == 0), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
